mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. It owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo/mfhi/mflo.
- It produces E_MDU_start and E_MDU_busy, which the hazard controller uses to stall D-stage MDU-related instructions.
- Multi-cycle latency is modelled with a down-counter. Results commit to HI/LO only when the counter expires.

---
 rtl/mdu_unit.sv | 110 +++++++++++
 tb/tb_mdu_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO and models multi-cycle latency with a
// down-counter, committing the captured 64-bit result when the counter expires.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDU_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } mdu_op_t;

  logic [31:0]   hi_reg, lo_reg;
  logic [63:0]   pending_reg;
  logic          div0_reg;
  logic          busy_reg;
  logic [CW-1:0] cnt_reg;

  logic          is_md_op, is_div_op;
  logic [63:0]   prod_s, prod_u, result_next;
  logic [31:0]   a_mag, b_mag, divisor, uq, ur, mq, mr, sq, sr;

  assign is_md_op  = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU) ||
                     (MDU_op == OP_DIV)  || (MDU_op == OP_DIVU);
  assign is_div_op = (MDU_op == OP_DIV) || (MDU_op == OP_DIVU);
  assign Start     = !reset && !busy_reg && !Req && is_md_op;

  // Signed divide works on magnitudes so 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u  = {32'd0, A} * {32'd0, B};
    a_mag   = A[31] ? (32'd0 - A) : A;
    b_mag   = B[31] ? (32'd0 - B) : B;
    divisor = (B == 32'd0) ? 32'd1 : B;
    uq      = A / divisor;
    ur      = A % divisor;
    mq      = (b_mag == 32'd0) ? 32'd0 : a_mag / b_mag;
    mr      = (b_mag == 32'd0) ? 32'd0 : a_mag % b_mag;
    sq      = (A[31] ^ B[31]) ? (32'd0 - mq) : mq;
    sr      = A[31] ? (32'd0 - mr) : mr;
    result_next = 64'd0;
    case (MDU_op)
      OP_MULT:  result_next = prod_s;
      OP_MULTU: result_next = prod_u;
      OP_DIV:   result_next = {sr, sq};
      OP_DIVU:  result_next = {ur, uq};
      default:  result_next = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pending_reg <= 64'd0;
      div0_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      cnt_reg     <= '0;
    end else if (busy_reg) begin
      // In-flight work is never cancelled by Req; only reset aborts it.
      if (cnt_reg == CW'(1)) begin
        if (!div0_reg) begin
          hi_reg <= pending_reg[63:32];
          lo_reg <= pending_reg[31:0];
        end
        cnt_reg  <= '0;
        busy_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg - CW'(1);
      end
    end else if (Start) begin
      pending_reg <= result_next;
      div0_reg    <= is_div_op && (B == 32'd0);
      cnt_reg     <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      busy_reg    <= 1'b1;
    end else if (!Req) begin
      if (MDU_op == OP_MTHI) hi_reg <= A;
      if (MDU_op == OP_MTLO) lo_reg <= A;
    end
  end

  assign Busy    = busy_reg;
  assign HI      = hi_reg;
  assign LO      = lo_reg;
  assign MDU_out = (MDU_op == OP_MFHI) ? hi_reg :
                   (MDU_op == OP_MFLO) ? lo_reg : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: hand-computed HI/LO results and exact Busy windows.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDU_op;
  logic [31:0] A, B;
  logic        Req;
  logic        Start, Busy;
  logic [31:0] HI, LO, MDU_out;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .MDU_op(MDU_op), .A(A), .B(B), .Req(Req),
    .Start(Start), .Busy(Busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div op, walk its Busy window, then check the committed HI/LO.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [15:0] req_mask,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    check({tag, "_idle_before"}, {31'd0, Busy}, 32'd0);
    MDU_op = op; A = a; B = b; Req = 1'b0;
    #1;
    check({tag, "_start"}, {31'd0, Start}, 32'd1);
    step();
    MDU_op = 4'd0; A = 32'hA5A5A5A5; B = 32'h5A5A5A5A;
    for (int i = 1; i <= n; i++) begin
      Req = req_mask[i];
      #1;
      check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
      check({tag, "_start_low"}, {31'd0, Start}, 32'd0);
      if (i == n) begin
        check({tag, "_hi_held"}, HI, exp_hi);
        check({tag, "_lo_held"}, LO, exp_lo);
      end
      step();
    end
    Req = 1'b0;
    exp_hi = new_hi;
    exp_lo = new_lo;
    #1;
    check({tag, "_busy_done"}, {31'd0, Busy}, 32'd0);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
    $display("op %0d A=0x%08h B=0x%08h -> HI=0x%08h LO=0x%08h", op, a, b, HI, LO);
  endtask

  task automatic single(input logic [3:0] op, input logic [31:0] a, input logic req);
    MDU_op = op; A = a; Req = req;
    step();
    MDU_op = 4'd0; Req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MDU_op = 4'd1; A = 32'd3; B = 32'd4; Req = 1'b0;
    #1;
    check("start_in_reset", {31'd0, Start}, 32'd0);
    step(); step();
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0; MDU_op = 4'd0;
    step();
    check("rst_mdu_out", MDU_out, 32'd0);

    run_op("mult",  4'd1, 32'hFFFFFFFF, 32'd2, MC, 16'd0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 4'd2, 32'hFFFFFFFF, 32'd2, MC, 16'd0, 32'h00000001, 32'hFFFFFFFE);
    run_op("div",   4'd3, 32'hFFFFFFF9, 32'd2, DC, 16'd0, 32'hFFFFFFFF, 32'hFFFFFFFD);

    single(4'd5, 32'h11, 1'b0);
    single(4'd6, 32'h22, 1'b0);
    exp_hi = 32'h11; exp_lo = 32'h22;
    check("mthi_11", HI, exp_hi);
    check("mtlo_22", LO, exp_lo);
    run_op("divu_by0", 4'd4, 32'd7, 32'd0, DC, 16'd0, 32'h11, 32'h22);
    run_op("div_ovf",  4'd3, 32'h80000000, 32'hFFFFFFFF, DC, 16'd0, 32'h0, 32'h80000000);
    run_op("divu",     4'd4, 32'hFFFFFFF9, 32'd2, DC, 16'd0, 32'h1, 32'h7FFFFFFC);
    run_op("div_neg_b", 4'd3, 32'd7, 32'hFFFFFFFE, DC, 16'd0, 32'h1, 32'hFFFFFFFD);

    single(4'd5, 32'h12345678, 1'b0);
    exp_hi = 32'h12345678;
    check("mthi", HI, exp_hi);
    MDU_op = 4'd7; #1;
    check("mfhi_out", MDU_out, 32'h12345678);
    MDU_op = 4'd8; #1;
    check("mflo_out", MDU_out, exp_lo);
    MDU_op = 4'd0; #1;
    check("none_out", MDU_out, 32'd0);
    MDU_op = 4'd12; #1;
    check("op12_out", MDU_out, 32'd0);
    step();

    single(4'd6, 32'hDEADBEEF, 1'b1);
    check("mtlo_req_lo", LO, exp_lo);

    MDU_op = 4'd3; A = 32'd100; B = 32'd7; Req = 1'b1;
    #1;
    check("div_req_start", {31'd0, Start}, 32'd0);
    step();
    MDU_op = 4'd0; Req = 1'b0;
    check("div_req_busy", {31'd0, Busy}, 32'd0);
    check("div_req_hi", HI, exp_hi);
    check("div_req_lo", LO, exp_lo);

    // Req during busy cycle 3 and during the commit cycle must not disturb the result.
    run_op("mult_req", 4'd1, 32'd3, 32'd5, MC, 16'b0000_0000_0010_1000, 32'd0, 32'd15);

    MDU_op = 4'd3; A = 32'd100; B = 32'd7;
    step();
    MDU_op = 4'd0;
    step(); step(); step();
    check("div_abort_busy_c4", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    for (int i = 0; i < DC; i++) step();
    check("abort_no_late_hi", HI, 32'd0);
    check("abort_no_late_lo", LO, 32'd0);
    run_op("mult_after", 4'd1, 32'd6, 32'd7, MC, 16'd0, 32'd0, 32'd42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
